// File: rtl/addr_exc_unit.sv
// Address-error exception unit: detects misaligned or privilege-violating
// fetch and data addresses, reports one exception to CP0 and holds off
// further reports until the handler returns.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   IDLE     | watching for faults; captures the first unstalled one
//   REPORT   | one-cycle addr_err strobe, exception requested
//   WAIT_ACK | exception still requested, waiting for CP0 to accept
//   BLOCK    | handler running; faults ignored until eret
module addr_exc_unit #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  input  logic             flush,
  input  logic             if_valid,
  input  logic [31:0]      if_pc,
  input  logic             mem_valid,
  input  logic [31:0]      mem_addr,
  input  logic [1:0]       mem_size,
  input  logic             mem_we,
  input  logic             user_mode,
  input  logic             exc_ack,
  input  logic             eret,
  output logic             addr_err,
  output logic [31:0]      badvaddr_p,
  output logic             exc_req,
  output logic [4:0]       exc_code,
  output logic             exc_from_if,
  output logic [CNT_W-1:0] err_count
);

  typedef enum logic [1:0] {IDLE, REPORT, WAIT_ACK, BLOCK} state_t;

  localparam logic [4:0] CODE_ADEL = 5'd4;
  localparam logic [4:0] CODE_ADES = 5'd5;

  state_t      state;
  logic        misaligned;
  logic        data_fault;
  logic        fetch_fault;
  logic        fault;
  logic [31:0] fault_addr;
  logic [4:0]  fault_code;
  logic        fault_from_if;

  // Fault detection; the data access belongs to the older instruction, so it wins.
  always_comb begin
    misaligned    = 1'b0;
    fault_addr    = if_pc;
    fault_code    = CODE_ADEL;
    fault_from_if = 1'b1;
    case (mem_size)
      2'b00:   misaligned = 1'b0;
      2'b01:   misaligned = mem_addr[0];
      default: misaligned = |mem_addr[1:0];
    endcase
    data_fault  = mem_valid & (misaligned | (user_mode & mem_addr[31]));
    fetch_fault = if_valid & ((|if_pc[1:0]) | (user_mode & if_pc[31]));
    fault       = data_fault | fetch_fault;
    if (data_fault) begin
      fault_addr    = mem_addr;
      fault_code    = mem_we ? CODE_ADES : CODE_ADEL;
      fault_from_if = 1'b0;
    end
  end

  // Sequencer with registered outputs; the count is bumped on entry to REPORT
  // so it already reflects the report during the strobe cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      addr_err    <= 1'b0;
      exc_req     <= 1'b0;
      badvaddr_p  <= '0;
      exc_code    <= '0;
      exc_from_if <= 1'b0;
      err_count   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (fault && !stall && !flush) begin
            state       <= REPORT;
            addr_err    <= 1'b1;
            exc_req     <= 1'b1;
            badvaddr_p  <= fault_addr;
            exc_code    <= fault_code;
            exc_from_if <= fault_from_if;
            if (err_count != {CNT_W{1'b1}})
              err_count <= err_count + 1'b1;
          end
        end
        REPORT: begin
          addr_err <= 1'b0;
          if (exc_ack) begin
            state   <= BLOCK;
            exc_req <= 1'b0;
          end else begin
            state   <= WAIT_ACK;
          end
        end
        WAIT_ACK: begin
          if (exc_ack) begin
            state   <= BLOCK;
            exc_req <= 1'b0;
          end
        end
        BLOCK: begin
          if (eret)
            state <= IDLE;
        end
        default: begin
          state    <= IDLE;
          addr_err <= 1'b0;
          exc_req  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_addr_exc_unit.sv
// Bench for addr_exc_unit: constant vector table, hand-written multi-cycle
// sequences, and randomized traffic against a transaction-level model.
module tb_addr_exc_unit;

  logic        clk = 1'b0;
  logic        rst, stall, flush, if_valid, mem_valid, mem_we, user_mode, exc_ack, eret;
  logic [31:0] if_pc, mem_addr;
  logic [1:0]  mem_size;

  logic        addr_err, exc_req, exc_from_if;
  logic [31:0] badvaddr_p;
  logic [4:0]  exc_code;
  logic [15:0] err_count;

  logic        addr_err_s, exc_req_s, exc_from_if_s;
  logic [31:0] badvaddr_p_s;
  logic [4:0]  exc_code_s;
  logic [1:0]  err_count_s;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  addr_exc_unit dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .if_valid(if_valid), .if_pc(if_pc), .mem_valid(mem_valid), .mem_addr(mem_addr),
    .mem_size(mem_size), .mem_we(mem_we), .user_mode(user_mode), .exc_ack(exc_ack),
    .eret(eret), .addr_err(addr_err), .badvaddr_p(badvaddr_p), .exc_req(exc_req),
    .exc_code(exc_code), .exc_from_if(exc_from_if), .err_count(err_count)
  );

  addr_exc_unit #(.CNT_W(2)) dut_small (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .if_valid(if_valid), .if_pc(if_pc), .mem_valid(mem_valid), .mem_addr(mem_addr),
    .mem_size(mem_size), .mem_we(mem_we), .user_mode(user_mode), .exc_ack(exc_ack),
    .eret(eret), .addr_err(addr_err_s), .badvaddr_p(badvaddr_p_s), .exc_req(exc_req_s),
    .exc_code(exc_code_s), .exc_from_if(exc_from_if_s), .err_count(err_count_s)
  );

  // Reference model: an exception is either outstanding (not yet accepted),
  // being serviced (accepted, awaiting eret), or absent.
  bit          m_outstanding, m_servicing, m_strobe;
  logic [31:0] m_bad;
  logic [4:0]  m_code;
  bit          m_from_if;
  int          m_reports;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic ref_fault(output bit hit, output logic [31:0] a, output logic [4:0] c,
                           output bit fi);
    int unsigned bytes;
    bit d, f;
    bytes = (mem_size == 2'd0) ? 1 : (mem_size == 2'd1) ? 2 : 4;
    d = mem_valid && (((mem_addr % bytes) != 0) || (user_mode && mem_addr >= 32'h8000_0000));
    f = if_valid  && (((if_pc % 4) != 0)        || (user_mode && if_pc    >= 32'h8000_0000));
    hit = d || f;
    if (d) begin a = mem_addr; c = mem_we ? 5'd5 : 5'd4; fi = 1'b0; end
    else   begin a = if_pc;    c = 5'd4;                 fi = 1'b1; end
  endtask

  task automatic model_edge();
    bit hit, fi;
    logic [31:0] a;
    logic [4:0] c;
    ref_fault(hit, a, c, fi);
    if (rst) begin
      m_outstanding = 0; m_servicing = 0; m_strobe = 0;
      m_bad = '0; m_code = '0; m_from_if = 0; m_reports = 0;
    end else if (m_servicing) begin
      if (eret) m_servicing = 0;
    end else if (m_outstanding) begin
      m_strobe = 0;
      if (exc_ack) begin m_outstanding = 0; m_servicing = 1; end
    end else if (hit && !stall && !flush) begin
      m_outstanding = 1; m_strobe = 1;
      m_bad = a; m_code = c; m_from_if = fi; m_reports++;
    end
  endtask

  // One clock: advance the model with the applied inputs, then compare.
  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
    check("m_addr_err", {31'd0, addr_err}, {31'd0, m_strobe});
    check("m_exc_req", {31'd0, exc_req}, {31'd0, m_outstanding});
    check("m_badvaddr", badvaddr_p, m_bad);
    check("m_exc_code", {27'd0, exc_code}, {27'd0, m_code});
    check("m_from_if", {31'd0, exc_from_if}, {31'd0, m_from_if});
    check("m_err_count", {16'd0, err_count}, (m_reports > 65535) ? 65535 : m_reports);
    check("m_err_count_w2", {30'd0, err_count_s}, (m_reports > 3) ? 3 : m_reports);
  endtask

  task automatic quiet();
    rst = 0; stall = 0; flush = 0; if_valid = 0; if_pc = '0; mem_valid = 0;
    mem_addr = '0; mem_size = 2'd0; mem_we = 0; user_mode = 0; exc_ack = 0; eret = 0;
  endtask

  task automatic do_reset();
    quiet();
    rst = 1;
    tick();
    rst = 0;
  endtask

  typedef struct {
    logic        stall, flush, if_valid;
    logic [31:0] if_pc;
    logic        mem_valid;
    logic [31:0] mem_addr;
    logic [1:0]  mem_size;
    logic        mem_we, user_mode;
    logic        e_err;
    logic [31:0] e_bad;
    logic [4:0]  e_code;
    logic        e_fi;
  } vec_t;

  vec_t vt[11];

  initial begin
    // stall flush ifv if_pc memv mem_addr size we user | err bad code fi
    vt[0]  = '{0,0,0,32'h0,        1,32'h0040_0002,2'b10,0,0, 1,32'h0040_0002,5'd4,0};
    vt[1]  = '{0,0,1,32'h0040_0001,1,32'h1000_0001,2'b01,1,0, 1,32'h1000_0001,5'd5,0};
    vt[2]  = '{0,0,1,32'h8000_0000,0,32'h0,        2'b00,0,1, 1,32'h8000_0000,5'd4,1};
    vt[3]  = '{1,0,1,32'h0000_0002,1,32'h0000_0001,2'b10,0,0, 0,32'h0,        5'd0,0};
    vt[4]  = '{0,1,1,32'h0000_0002,1,32'h0000_0001,2'b10,1,0, 0,32'h0,        5'd0,0};
    vt[5]  = '{0,0,0,32'h0,        1,32'h0000_0003,2'b00,1,0, 0,32'h0,        5'd0,0};
    vt[6]  = '{0,0,0,32'h0,        1,32'h0000_1002,2'b11,1,0, 1,32'h0000_1002,5'd5,0};
    vt[7]  = '{0,0,1,32'h0000_0100,1,32'h8000_0010,2'b10,0,1, 1,32'h8000_0010,5'd4,0};
    vt[8]  = '{0,0,1,32'h8000_0000,1,32'h8000_0000,2'b10,0,0, 0,32'h0,        5'd0,0};
    vt[9]  = '{0,0,0,32'h0,        1,32'h0000_0002,2'b01,1,0, 0,32'h0,        5'd0,0};
    vt[10] = '{0,0,1,32'h0000_0002,1,32'h0000_0004,2'b10,1,1, 1,32'h0000_0002,5'd4,1};

    quiet();
    rst = 1;
    @(posedge clk); #1;
    do_reset();
    check("reset_addr_err", {31'd0, addr_err}, 32'd0);
    check("reset_exc_req", {31'd0, exc_req}, 32'd0);
    check("reset_badvaddr", badvaddr_p, 32'd0);
    check("reset_err_count", {16'd0, err_count}, 32'd0);

    for (int i = 0; i < 11; i++) begin
      do_reset();
      stall = vt[i].stall; flush = vt[i].flush; if_valid = vt[i].if_valid; if_pc = vt[i].if_pc;
      mem_valid = vt[i].mem_valid; mem_addr = vt[i].mem_addr; mem_size = vt[i].mem_size;
      mem_we = vt[i].mem_we; user_mode = vt[i].user_mode;
      tick();
      check($sformatf("vec%0d_addr_err", i), {31'd0, addr_err}, {31'd0, vt[i].e_err});
      check($sformatf("vec%0d_exc_req", i), {31'd0, exc_req}, {31'd0, vt[i].e_err});
      check($sformatf("vec%0d_badvaddr", i), badvaddr_p, vt[i].e_bad);
      check($sformatf("vec%0d_exc_code", i), {27'd0, exc_code}, {27'd0, vt[i].e_code});
      check($sformatf("vec%0d_from_if", i), {31'd0, exc_from_if}, {31'd0, vt[i].e_fi});
      check($sformatf("vec%0d_err_count", i), {16'd0, err_count}, {31'd0, vt[i].e_err});
      quiet();
      tick();
      check($sformatf("vec%0d_strobe_drop", i), {31'd0, addr_err}, 32'd0);
    end

    // User fetch of kernel space, then faults/eret ignored until ack and eret.
    do_reset();
    user_mode = 1; if_valid = 1; if_pc = 32'h8000_0000;
    tick();
    check("seq_fetch_err", {31'd0, addr_err}, 32'd1);
    check("seq_fetch_code", {27'd0, exc_code}, 32'd4);
    check("seq_fetch_from_if", {31'd0, exc_from_if}, 32'd1);
    if_valid = 0; mem_valid = 1; mem_addr = 32'h0000_0003; mem_size = 2'b10; eret = 1;
    tick();
    check("seq_wait_err", {31'd0, addr_err}, 32'd0);
    check("seq_wait_req", {31'd0, exc_req}, 32'd1);
    check("seq_wait_bad", badvaddr_p, 32'h8000_0000);
    tick();
    check("seq_wait_eret_ignored", {31'd0, exc_req}, 32'd1);
    eret = 0; exc_ack = 1;
    tick();
    check("seq_block_req", {31'd0, exc_req}, 32'd0);
    exc_ack = 0;
    tick();
    check("seq_block_ignore_err", {31'd0, addr_err}, 32'd0);
    check("seq_block_ignore_bad", badvaddr_p, 32'h8000_0000);
    eret = 1;
    tick();
    check("seq_eret_no_err", {31'd0, addr_err}, 32'd0);
    eret = 0;
    tick();
    check("seq_new_err", {31'd0, addr_err}, 32'd1);
    check("seq_new_bad", badvaddr_p, 32'h0000_0003);
    check("seq_new_from_if", {31'd0, exc_from_if}, 32'd0);
    check("seq_new_count", {16'd0, err_count}, 32'd2);
    // Ack arriving in the strobe cycle skips the wait.
    mem_valid = 0; exc_ack = 1;
    tick();
    check("seq_ack_in_report", {31'd0, exc_req}, 32'd0);

    // Reset while waiting for acknowledge.
    do_reset();
    mem_valid = 1; mem_addr = 32'h0000_0102; mem_size = 2'b10; mem_we = 1;
    tick();
    mem_valid = 0;
    tick();
    check("rst_pre_req", {31'd0, exc_req}, 32'd1);
    rst = 1;
    tick();
    rst = 0;
    check("rst_wait_req", {31'd0, exc_req}, 32'd0);
    check("rst_wait_bad", badvaddr_p, 32'd0);
    check("rst_wait_count", {16'd0, err_count}, 32'd0);
    check("rst_wait_code", {27'd0, exc_code}, 32'd0);

    // Five reports: narrow counter saturates at 3.
    for (int k = 0; k < 5; k++) begin
      mem_valid = 1; mem_addr = 32'h0000_0201; mem_size = 2'b01; exc_ack = 0; eret = 0;
      tick();
      mem_valid = 0; exc_ack = 1;
      tick();
      exc_ack = 0; eret = 1;
      tick();
      eret = 0;
    end
    check("sat_count_w2", {30'd0, err_count_s}, 32'd3);
    check("sat_count_w16", {16'd0, err_count}, 32'd5);

    // Randomized traffic against the model.
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      rst       = ($urandom_range(0, 199) == 0);
      stall     = ($urandom_range(0, 7) == 0);
      flush     = ($urandom_range(0, 7) == 0);
      if_valid  = $urandom_range(0, 1);
      if_pc     = $urandom;
      if ($urandom_range(0, 2) != 0) if_pc[1:0] = 2'b00;
      if ($urandom_range(0, 1) != 0) if_pc[31] = 1'b0;
      mem_valid = ($urandom_range(0, 2) == 0);
      mem_addr  = $urandom;
      if ($urandom_range(0, 2) != 0) mem_addr[1:0] = 2'b00;
      if ($urandom_range(0, 1) != 0) mem_addr[31] = 1'b0;
      mem_size  = 2'($urandom_range(0, 3));
      mem_we    = $urandom_range(0, 1);
      user_mode = ($urandom_range(0, 3) == 0);
      exc_ack   = ($urandom_range(0, 3) == 0);
      eret      = ($urandom_range(0, 3) == 0);
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
